// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - MOSI/MISO byte streams and register bus between SPI engine, sequencer and CSR decoder
interface spi_reg_ctrl_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);
   logic [7:0]        s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [7:0]        m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_we;
   logic              bus_stb;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;

   // slave: the sequencer's view; master: SPI engine plus register file side
   modport slave (
      input  s_axis_tdata, s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tvalid,
      input  m_axis_tready,
      output bus_addr, bus_wdata, bus_we, bus_stb,
      input  bus_ack, bus_rdata
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tvalid,
      output m_axis_tready,
      input  bus_addr, bus_wdata, bus_we, bus_stb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command/register sequencer: single/burst register reads and writes
// Optional bus ack timeout and sticky err output: SPI_REG_CTRL_BUS_TIMEOUT_EN
module spi_reg_ctrl #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   spi_reg_ctrl_if.slave io,
`ifdef SPI_REG_CTRL_BUS_TIMEOUT_EN
   output logic          err,
`endif
   output logic          busy
);
   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

   if (DATA_W % 8 != 0 || DATA_W < 8 || ADDR_W < 1 || ADDR_W > 7 || TIMEOUT < 1) begin : g_bad_params
      $error("spi_reg_ctrl: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_CMD,
      S_WDATA,
      S_WBUS,
      S_RBUS,
      S_RPUSH
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              cs_meta;
   logic              cs_sync;
   logic [CNT_W-1:0]  cnt;
   logic              abort;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] wdata_nxt;
   logic [DATA_W-1:0] rshift;
   logic              s_ready;
   logic              m_valid;
   logic              stb;
   logic              we;
   logic              s_hs;
   logic              m_hs;
   logic              last_byte;
   logic              bus_ev;
   logic              timed_out;

   assign s_hs      = s_ready && io.s_axis_tvalid;
   assign m_hs      = m_valid && io.m_axis_tready;
   assign last_byte = (cnt == CNT_W'(NB - 1));
   assign bus_ev    = io.bus_ack || timed_out;

   if (NB > 1) begin : g_wshift
      assign wdata_nxt = {wdata_q[DATA_W-9:0], io.s_axis_tdata};
   end else begin : g_wbyte
      assign wdata_nxt = io.s_axis_tdata;
   end

`ifdef SPI_REG_CTRL_BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt;

   assign timed_out = stb && !io.bus_ack && (to_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (stb && !bus_ev) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   // err survives until software issues its next command
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (timed_out) begin
         err <= 1'b1;
      end else if (state == S_CMD && s_hs) begin
         err <= 1'b0;
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   // cs idles high, so the synchroniser resets to the deselected level
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_meta <= 1'b1;
         cs_sync <= 1'b1;
      end else begin
         cs_meta <= cs;
         cs_sync <= cs_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_CMD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      stb       = 1'b0;
      we        = 1'b0;
      case (state)
         S_CMD: begin
            s_ready = !cs_sync;
            if (!cs_sync && io.s_axis_tvalid) begin
               state_nxt = io.s_axis_tdata[7] ? S_RBUS : S_WDATA;
            end
         end
         S_WDATA: begin
            s_ready = !cs_sync;
            if (cs_sync) begin
               state_nxt = S_CMD;
            end else if (io.s_axis_tvalid && last_byte) begin
               state_nxt = S_WBUS;
            end
         end
         S_WBUS: begin
            stb = 1'b1;
            we  = 1'b1;
            if (bus_ev) begin
               state_nxt = (abort || cs_sync) ? S_CMD : S_WDATA;
            end
         end
         // after a deselect the next command's bytes must wait for CMD
         S_RBUS: begin
            stb     = 1'b1;
            s_ready = !cs_sync && !abort;
            if (bus_ev) begin
               state_nxt = (abort || cs_sync) ? S_CMD : S_RPUSH;
            end
         end
         S_RPUSH: begin
            s_ready = !cs_sync;
            m_valid = !cs_sync;
            if (cs_sync) begin
               state_nxt = S_CMD;
            end else if (io.m_axis_tready && last_byte) begin
               state_nxt = S_RBUS;
            end
         end
         default: state_nxt = S_CMD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         abort   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rshift  <= '0;
      end else begin
         case (state)
            S_CMD: begin
               cnt   <= '0;
               abort <= 1'b0;
               if (s_hs) begin
                  addr_q <= io.s_axis_tdata[ADDR_W-1:0];
               end
            end
            S_WDATA: begin
               if (cs_sync) begin
                  cnt <= '0;
               end else if (s_hs) begin
                  wdata_q <= wdata_nxt;
                  cnt     <= last_byte ? '0 : cnt + 1'b1;
               end
            end
            // a started bus cycle always completes; deselect only marks it for discard
            S_WBUS, S_RBUS: begin
               cnt <= '0;
               if (cs_sync) begin
                  abort <= 1'b1;
               end
               if (bus_ev) begin
                  addr_q <= addr_q + 1'b1;
                  if (state == S_RBUS) begin
                     rshift <= timed_out ? '1 : io.bus_rdata;
                  end
               end
            end
            S_RPUSH: begin
               if (cs_sync) begin
                  cnt <= '0;
               end else if (m_hs) begin
                  rshift <= rshift << 8;
                  cnt    <= last_byte ? '0 : cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.s_axis_tready = s_ready;
   assign io.m_axis_tvalid = m_valid;
   assign io.m_axis_tdata  = rshift[DATA_W-1 -: 8];
   assign io.bus_addr      = addr_q;
   assign io.bus_wdata     = wdata_q;
   assign io.bus_we        = we;
   assign io.bus_stb       = stb;
   assign busy             = (state != S_CMD);
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - randomized self-checking bench for spi_reg_ctrl against a register-file model
module tb_spi_reg_ctrl;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;

   typedef struct {
      logic [6:0]  addr;
      logic        we;
      logic [31:0] data;
      int          cyc;
   } bus_op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cs  = 1'b1;
   logic busy;
`ifdef SPI_REG_CTRL_BUS_TIMEOUT_EN
   logic err;
`endif

   spi_reg_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

   spi_reg_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .cs   (cs),
      .io   (sif),
`ifdef SPI_REG_CTRL_BUS_TIMEOUT_EN
      .err  (err),
`endif
      .busy (busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] regs    [128];
   logic [31:0] ref_mem [128];
   bus_op_t     bus_log [$];
   logic [7:0]  miso_q  [$];
   logic [31:0] wq      [$];
   int          miso_target = 1 << 30;
   bit          miso_hold   = 0;
   int          ack_delay   = -1;
   bit          ack_en      = 1;
   int          wcnt        = 0;
   bit          active      = 0;
   int          cyc         = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sif.m_axis_tready = miso_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   endtask

   // register file: acks after a random or forced delay, logs every completed cycle
   initial begin
      bus_op_t op;
      sif.bus_ack   = 1'b0;
      sif.bus_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         sif.bus_ack = 1'b0;
         if (rst) begin
            active = 0;
         end else if (sif.bus_stb) begin
            if (!active) begin
               active = 1;
               cyc    = 0;
               wcnt   = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            end
            cyc++;
            if (ack_en && wcnt == 0) begin
               sif.bus_ack = 1'b1;
               active      = 0;
               op.addr     = sif.bus_addr;
               op.we       = sif.bus_we;
               op.data     = sif.bus_wdata;
               op.cyc      = cyc;
               if (sif.bus_we) regs[sif.bus_addr] = sif.bus_wdata;
               else sif.bus_rdata = regs[sif.bus_addr];
               bus_log.push_back(op);
            end else if (wcnt > 0) begin
               wcnt--;
            end
         end else begin
            active = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (sif.m_axis_tvalid && sif.m_axis_tready) begin
         miso_q.push_back(sif.m_axis_tdata);
         if (miso_q.size() >= miso_target) miso_hold = 1;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 0;
      sif.s_axis_tdata  = b;
      sif.s_axis_tvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = sif.s_axis_tready;
         tick();
      end
      sif.s_axis_tvalid = 1'b0;
      if (!done) check("s_axis_handshake_timeout", 0, 1);
   endtask

   task automatic idle_maybe();
      if ($urandom_range(0, 2) == 0) tick();
   endtask

   task automatic cs_low();
      cs = 1'b0;
      repeat (3) tick();
   endtask

   task automatic cs_high_wait();
      cs = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         tick();
      end
      check("busy_after_cs", busy, 0);
      tick();
   endtask

   task automatic write_txn(input logic [6:0] addr, input logic [31:0] words[$], input int extra);
      logic [6:0] ea;
      bus_log.delete();
      miso_q.delete();
      miso_hold   = 0;
      miso_target = 1 << 30;
      cs_low();
      send_byte({1'b0, addr});
      foreach (words[w]) begin
         for (int b = 0; b < 4; b++) begin
            send_byte(words[w][31 - 8 * b -: 8]);
            idle_maybe();
         end
      end
      for (int e = 0; e < extra; e++) send_byte(8'($urandom));
      cs_high_wait();
      check("wr_count", bus_log.size(), words.size());
      for (int i = 0; i < words.size() && i < bus_log.size(); i++) begin
         ea = addr + 7'(i);
         check("wr_addr", bus_log[i].addr, ea);
         check("wr_we", bus_log[i].we, 1);
         check("wr_data", bus_log[i].data, words[i]);
      end
      for (int i = 0; i < words.size(); i++) begin
         ea = addr + 7'(i);
         ref_mem[ea] = words[i];
      end
      check("wr_no_miso", miso_q.size(), 0);
   endtask

   task automatic read_txn(input logic [6:0] addr, input int n);
      logic [6:0]  ea;
      logic [31:0] word;
      bus_log.delete();
      miso_q.delete();
      miso_hold   = 0;
      miso_target = 4 * n;
      cs_low();
      send_byte({1'b1, addr});
      for (int d = 0; d < 4 * n; d++) begin
         send_byte(8'($urandom));
         idle_maybe();
      end
      for (int i = 0; i < 500 && miso_q.size() < 4 * n; i++) tick();
      check("rd_miso_count", miso_q.size(), 4 * n);
      cs_high_wait();
      for (int i = 0; i < n; i++) begin
         ea   = addr + 7'(i);
         word = ref_mem[ea];
         for (int b = 0; b < 4; b++) begin
            if (4 * i + b < miso_q.size())
               check("rd_byte", miso_q[4 * i + b], (word >> (24 - 8 * b)) & 32'hFF);
         end
      end
      check("rd_bus_count", bus_log.size(), n + 1);
      for (int i = 0; i <= n && i < bus_log.size(); i++) begin
         ea = addr + 7'(i);
         check("rd_addr", bus_log[i].addr, ea);
         check("rd_we", bus_log[i].we, 0);
      end
      miso_hold = 0;
   endtask

   initial begin
      logic [6:0] a;
      int         n;
      for (int i = 0; i < 128; i++) begin
         regs[i]    = $urandom;
         ref_mem[i] = regs[i];
      end
      sif.s_axis_tdata  = '0;
      sif.s_axis_tvalid = 1'b0;
      sif.m_axis_tready = 1'b1;

      rst = 1'b1;
      cs  = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_s_tready", sif.s_axis_tready, 0);
      check("rst_m_tvalid", sif.m_axis_tvalid, 0);
      check("rst_m_tdata", sif.m_axis_tdata, 0);
      check("rst_stb", sif.bus_stb, 0);
      check("rst_we", sif.bus_we, 0);
      check("rst_addr", sif.bus_addr, 0);
      check("rst_wdata", sif.bus_wdata, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      cs  = 1'b1;
      repeat (3) tick();

      wq.delete();
      wq.push_back(32'hDEADBEEF);
      write_txn(7'd5, wq, 0);

      regs[3] = 32'h11223344; ref_mem[3] = 32'h11223344;
      regs[4] = 32'h55667788; ref_mem[4] = 32'h55667788;
      read_txn(7'd3, 2);

      wq.delete();
      wq.push_back($urandom);
      wq.push_back($urandom);
      write_txn(7'h7F, wq, 0);

      wq.delete();
      write_txn(7'd2, wq, 2);
      wq.push_back($urandom);
      write_txn(7'd2, wq, 0);

      // deselect while a read bus cycle waits on a slow ack, then reselect early
      bus_log.delete();
      miso_q.delete();
      miso_hold   = 0;
      miso_target = 1 << 30;
      ack_delay   = 5;
      cs_low();
      send_byte(8'h81);
      cs = 1'b1;
      repeat (3) tick();
      cs = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      check("abort_stb_held", sif.bus_stb, 1);
      check("abort_tready_low", sif.s_axis_tready, 0);
      cs_high_wait();
      ack_delay = -1;
      check("abort_bus_count", bus_log.size(), 1);
      if (bus_log.size() > 0) begin
         check("abort_addr", bus_log[0].addr, 1);
         check("abort_stb_cycles", bus_log[0].cyc, 6);
      end
      check("abort_no_miso", miso_q.size(), 0);

      // reset while a write bus cycle is outstanding
      bus_log.delete();
      ack_delay = 10;
      cs_low();
      send_byte(8'h05);
      for (int b = 0; b < 4; b++) send_byte(8'($urandom));
      @(negedge clk);
      check("rstmid_stb_before", sif.bus_stb, 1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("rstmid_stb", sif.bus_stb, 0);
      check("rstmid_busy", busy, 0);
      rst = 1'b0;
      cs  = 1'b1;
      ack_delay = -1;
      repeat (4) tick();
      check("rstmid_no_bus", bus_log.size(), 0);

      for (int t = 0; t < 25; t++) begin
         a = 7'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            wq.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) wq.push_back($urandom);
            write_txn(a, wq, $urandom_range(0, 3));
         end else begin
            read_txn(a, $urandom_range(1, 3));
         end
      end

`ifdef SPI_REG_CTRL_BUS_TIMEOUT_EN
      ack_en = 0;
      miso_q.delete();
      miso_hold   = 0;
      miso_target = 4;
      cs_low();
      send_byte(8'h81);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!sif.bus_stb) break;
         n++;
         tick();
      end
      check("to_stb_cycles", n, 16);
      for (int i = 0; i < 200 && miso_q.size() < 4; i++) tick();
      check("to_miso_count", miso_q.size(), 4);
      for (int b = 0; b < 4 && b < miso_q.size(); b++) check("to_miso_ones", miso_q[b], 8'hFF);
      check("to_err_set", err, 1);
      cs_high_wait();
      ack_en    = 1;
      miso_hold = 0;
      check("to_err_sticky", err, 1);
      cs_low();
      send_byte(8'h00);
      @(negedge clk);
      check("to_err_cleared", err, 0);
      cs_high_wait();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
